// File: rtl/peripheral_bfm_ahb4_pkg.sv
// rtl/peripheral_bfm_ahb4_pkg.sv - shared codes, FSM states and response helper for the BFM slave
package peripheral_bfm_ahb4_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Out-of-range decode wins over an unsupported size.
    function automatic logic [1:0] addr_resp(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [31:0] limit);
        if (addr >= limit) return RESP_DECERR;
        if (size != 3'd2) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/peripheral_bfm_slave_mem_ahb4.sv
// rtl/peripheral_bfm_slave_mem_ahb4.sv - 1W/1R word array, byte-strobe write, asynchronous read
module peripheral_bfm_slave_mem_ahb4 #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_bfm_slave_ahb4.sv
// rtl/peripheral_bfm_slave_ahb4.sv - AXI-style BFM slave: word memory behind independent write/read responders
// Optional random backpressure via PERIPHERAL_BFM_SLAVE_STALL_EN.
module peripheral_bfm_slave_ahb4
    import peripheral_bfm_ahb4_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

    logic stall;

`ifdef PERIPHERAL_BFM_SLAVE_STALL_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1, free-running from reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    logic unused_wid;
    assign unused_wid = ^wid;

    w_state_e      w_state;
    logic          awready_q, wready_q;
    logic [3:0]    w_id, w_len, w_cnt;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_burst, w_code;
    logic          w_lerr;
    logic          aw_hs, w_hs, w_final, w_beat_err, mem_we;

    assign awready    = awready_q & ~stall;
    assign wready     = wready_q & ~stall;
    assign aw_hs      = awvalid & awready;
    assign w_hs       = wvalid & wready;
    assign w_final    = (w_cnt == w_len);
    assign w_beat_err = (wlast != w_final);
    assign mem_we     = (w_state == W_DATA) && w_hs && (w_code == RESP_OKAY);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
            w_id      <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_burst   <= '0;
            w_cnt     <= '0;
            w_code    <= '0;
            w_lerr    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        w_id      <= awid;
                        w_idx     <= awaddr[AW+1:2];
                        w_len     <= awlen;
                        w_burst   <= awburst;
                        w_cnt     <= '0;
                        w_code    <= addr_resp(awaddr, awsize, MEM_BYTES);
                        w_lerr    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_cnt <= w_cnt + 4'd1;
                        if (w_burst != BURST_FIXED) w_idx <= w_idx + 1'b1;
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid   <= 1'b1;
                            bid      <= w_id;
                            // Decode/size errors outrank a wlast framing error.
                            if (w_code != RESP_OKAY)       bresp <= w_code;
                            else if (w_lerr | w_beat_err)  bresp <= RESP_SLVERR;
                            else                           bresp <= RESP_OKAY;
                            w_state  <= W_RESP;
                        end else begin
                            w_lerr <= w_lerr | w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        bid       <= '0;
                        bresp     <= '0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_e      r_state;
    logic          arready_q, rvalid_q, r_shown;
    logic [3:0]    r_len, r_cnt;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_burst;
    logic [31:0]   mem_rdata;
    logic          ar_hs, r_hs;

    // Once a beat has been shown, the stall gate can no longer withdraw it.
    assign rvalid  = rvalid_q & (r_shown | ~stall);
    assign arready = arready_q & ~stall;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;
    assign rdata   = (rvalid_q && rresp == RESP_OKAY) ? mem_rdata : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_shown   <= 1'b0;
            rid       <= '0;
            rresp     <= '0;
            rlast     <= 1'b0;
            r_idx     <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
        end else begin
            if (r_hs)        r_shown <= 1'b0;
            else if (rvalid) r_shown <= 1'b1;

            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rid       <= arid;
                        r_idx     <= araddr[AW+1:2];
                        r_len     <= arlen;
                        r_burst   <= arburst;
                        r_cnt     <= '0;
                        rresp     <= addr_resp(araddr, arsize, MEM_BYTES);
                        rlast     <= (arlen == 4'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast) begin
                            rvalid_q  <= 1'b0;
                            rlast     <= 1'b0;
                            rid       <= '0;
                            rresp     <= '0;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            if (r_burst != BURST_FIXED) r_idx <= r_idx + 1'b1;
                            rlast <= ((r_cnt + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    peripheral_bfm_slave_mem_ahb4 #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (w_idx),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (r_idx),
        .rdata (mem_rdata)
    );

endmodule
